// File: rtl/pq_expiry_dispatcher.sv
// Pops expired entries from a time-ordered queue head and presents them as events; optional late counter under PQ_LATE_CNT_EN.
// Latency: pop_o to evt_valid_o is 2 cycles (IDLE -> SETTLE -> EMIT); back-to-back dispatch every 3 cycles.
// Backpressure: evt_ready_i low holds EMIT with stable event data and blocks further pops.
module pq_expiry_dispatcher #(
    parameter int TIME_WIDTH  = 24,
    parameter int ID_WIDTH    = 24,
    parameter int LATE_THRESH = 100
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    output logic [TIME_WIDTH-1:0] time_o,
    input  logic                  head_valid_i,
    input  logic [TIME_WIDTH-1:0] head_data_i,
    input  logic [ID_WIDTH-1:0]   head_id_i,
    output logic                  pop_o,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [ID_WIDTH-1:0]   evt_id_o,
    output logic [TIME_WIDTH-1:0] evt_time_o,
    output logic [15:0]           late_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [TIME_WIDTH-1:0] time_q;
    logic [TIME_WIDTH-1:0] diff;
    logic                  expired;
    logic [ID_WIDTH-1:0]   evt_id_q;
    logic [TIME_WIDTH-1:0] evt_time_q;

    // Modular distance; MSB clear means the deadline is now or in the past, which keeps working across wrap.
    assign diff    = time_q - head_data_i;
    assign expired = ~diff[TIME_WIDTH-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (head_valid_i && expired) state_d = SETTLE;
            SETTLE:  state_d = EMIT;
            EMIT:    if (evt_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_o       = 1'b0;
        evt_valid_o = 1'b0;
        case (state_q)
            IDLE:    pop_o = head_valid_i & expired;
            EMIT:    evt_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            time_q <= '0;
        end else if (en_i) begin
            time_q <= time_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            evt_id_q   <= '0;
            evt_time_q <= '0;
        end else if (pop_o) begin
            evt_id_q   <= head_id_i;
            evt_time_q <= head_data_i;
        end
    end

    assign time_o     = time_q;
    assign evt_id_o   = evt_id_q;
    assign evt_time_o = evt_time_q;

    if (LATE_THRESH < 0) begin : g_thresh_chk
        $error("LATE_THRESH must be non-negative");
    end

`ifdef PQ_LATE_CNT_EN
    localparam logic [TIME_WIDTH-1:0] LATE_T = TIME_WIDTH'(LATE_THRESH);

    logic [15:0] late_cnt_q;
    logic        late;

    assign late = expired && (diff > LATE_T);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            late_cnt_q <= '0;
        end else if (pop_o && late && (late_cnt_q != 16'hFFFF)) begin
            late_cnt_q <= late_cnt_q + 16'd1;
        end
    end

    assign late_cnt_o = late_cnt_q;
`else
    assign late_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pq_expiry_dispatcher.sv
// Directed bench for pq_expiry_dispatcher: 24-bit instance for dispatch/backpressure/late/reset, 8-bit instance for wrap.
// Expected pops and events are queued at stimulus time; negedge monitors pop and compare.
module tb_pq_expiry_dispatcher;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        en_i;
    logic        head_valid;
    logic [23:0] head_data;
    logic [23:0] head_id;
    logic        evt_ready;
    logic [23:0] time_o;
    logic        pop;
    logic        evt_valid;
    logic [23:0] evt_id;
    logic [23:0] evt_time;
    logic [15:0] late_cnt;

    logic        w_head_valid;
    logic [7:0]  w_head_data;
    logic [23:0] w_head_id;
    logic        w_ready;
    logic [7:0]  w_time;
    logic        w_pop;
    logic        w_evt_valid;
    logic [23:0] w_evt_id;
    logic [7:0]  w_evt_time;
    logic [15:0] w_late;

    pq_expiry_dispatcher dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .time_o(time_o),
        .head_valid_i(head_valid), .head_data_i(head_data), .head_id_i(head_id),
        .pop_o(pop), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
        .evt_id_o(evt_id), .evt_time_o(evt_time), .late_cnt_o(late_cnt)
    );

    pq_expiry_dispatcher #(.TIME_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .time_o(w_time),
        .head_valid_i(w_head_valid), .head_data_i(w_head_data), .head_id_i(w_head_id),
        .pop_o(w_pop), .evt_valid_o(w_evt_valid), .evt_ready_i(w_ready),
        .evt_id_o(w_evt_id), .evt_time_o(w_evt_time), .late_cnt_o(w_late)
    );

    typedef struct {
        logic [23:0] id;
        logic [23:0] tm;
        int          t_acc;
    } ev_t;

    int  checks   = 0;
    int  failures = 0;
    int  pop_q[$];
    ev_t ev_q[$];
    int  pop8_q[$];
    ev_t ev8_q[$];
    ev_t em;
    ev_t ew;

`ifdef PQ_LATE_CNT_EN
    localparam int LATE_EXP = 1;
`else
    localparam int LATE_EXP = 0;
`endif

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(string name, int act, int req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    function automatic ev_t mk(logic [23:0] id, logic [23:0] tm, int t_acc);
        ev_t e;
        e.id = id;
        e.tm = tm;
        e.t_acc = t_acc;
        return e;
    endfunction

    // Step to the cycle whose time_o equals t, sampled 1 time unit after the edge.
    task automatic wait_time(int t);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (time_o != 24'(t) && n < 1000);
        if (time_o != 24'(t)) fail("wait_time", int'(time_o), t);
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (pop) begin
                if (pop_q.size() == 0) fail("unexpected_pop_at_time", int'(time_o), -1);
                else check("pop_time", 32'(time_o), 32'(pop_q.pop_front()));
            end
            if (evt_valid) begin
                if (ev_q.size() == 0) begin
                    fail("unexpected_evt_at_time", int'(time_o), -1);
                end else if (evt_ready) begin
                    em = ev_q.pop_front();
                    check("evt_id", 32'(evt_id), 32'(em.id));
                    check("evt_time", 32'(evt_time), 32'(em.tm));
                    check("evt_accept_time", 32'(time_o), 32'(em.t_acc));
                end else begin
                    check("evt_id_hold", 32'(evt_id), 32'(ev_q[0].id));
                    check("evt_time_hold", 32'(evt_time), 32'(ev_q[0].tm));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            if (w_pop) begin
                if (pop8_q.size() == 0) fail("w_unexpected_pop_at_time", int'(w_time), -1);
                else check("w_pop_time", 32'(w_time), 32'(pop8_q.pop_front()));
            end
            if (w_evt_valid && w_ready) begin
                if (ev8_q.size() == 0) begin
                    fail("w_unexpected_evt_at_time", int'(w_time), -1);
                end else begin
                    ew = ev8_q.pop_front();
                    check("w_evt_id", 32'(w_evt_id), 32'(ew.id));
                    check("w_evt_time", 32'(w_evt_time), 32'(ew.tm));
                    check("w_evt_accept_time", 32'(w_time), 32'(ew.t_acc & 255));
                end
            end
        end
    end

    initial begin
        rst_ni       = 1'b0;
        en_i         = 1'b0;
        head_valid   = 1'b0;
        head_data    = '0;
        head_id      = '0;
        evt_ready    = 1'b1;
        w_head_valid = 1'b0;
        w_head_data  = '0;
        w_head_id    = '0;
        w_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_time", 32'(time_o), 0);
        check("rst_pop", 32'(pop), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_late", 32'(late_cnt), 0);
        check("rst_evt_id", 32'(evt_id), 0);
        check("rst_evt_time", 32'(evt_time), 0);
        check("rst_w_time", 32'(w_time), 0);

        // Basic dispatch: pop at 10, event visible at 12.
        rst_ni = 1'b1; en_i = 1'b1;
        head_valid = 1'b1; head_data = 24'd10; head_id = 24'd7;
        pop_q.push_back(10); ev_q.push_back(mk(24'd7, 24'd10, 12));
        wait_time(11); head_valid = 1'b0;

        // Backpressure: event held 20 cycles while a second expired head waits.
        wait_time(14);
        check("late_before", 32'(late_cnt), 0);
        evt_ready = 1'b0;
        head_valid = 1'b1; head_data = 24'd20; head_id = 24'h21;
        pop_q.push_back(20); ev_q.push_back(mk(24'h21, 24'd20, 42));
        wait_time(21); head_data = 24'd25; head_id = 24'h22;
        pop_q.push_back(43); ev_q.push_back(mk(24'h22, 24'd25, 45));
        wait_time(42); evt_ready = 1'b1;
        wait_time(44); head_valid = 1'b0;

        // Late entry (diff 200) then threshold boundary (diff 100, not late).
        wait_time(300);
        head_valid = 1'b1; head_data = 24'd100; head_id = 24'h33;
        pop_q.push_back(300); ev_q.push_back(mk(24'h33, 24'd100, 302));
        wait_time(301); head_valid = 1'b0;
        wait_time(305); check("late_after_200", 32'(late_cnt), 32'(LATE_EXP));
        wait_time(310);
        head_valid = 1'b1; head_data = 24'd210; head_id = 24'h34;
        pop_q.push_back(310); ev_q.push_back(mk(24'h34, 24'd210, 312));
        wait_time(311); head_valid = 1'b0;
        wait_time(315); check("late_after_100", 32'(late_cnt), 32'(LATE_EXP));

        // Empty queue with an "expired" deadline of 0 for 50 cycles.
        wait_time(320); head_data = 24'd0;
        wait_time(370);

        // Back-to-back expired entries every 3 cycles.
        wait_time(380);
        head_valid = 1'b1; head_data = 24'd370; head_id = 24'h41;
        pop_q.push_back(380); ev_q.push_back(mk(24'h41, 24'd370, 382));
        wait_time(381); head_data = 24'd375; head_id = 24'h42;
        pop_q.push_back(383); ev_q.push_back(mk(24'h42, 24'd375, 385));
        wait_time(384); head_data = 24'd379; head_id = 24'h43;
        pop_q.push_back(386); ev_q.push_back(mk(24'h43, 24'd379, 388));
        wait_time(387); head_valid = 1'b0;

        // Counter hold while disabled.
        wait_time(400); en_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("time_hold", 32'(time_o), 400);
        en_i = 1'b1;

        // Reset while in EMIT discards the held event.
        wait_time(415); evt_ready = 1'b0;
        wait_time(420);
        head_valid = 1'b1; head_data = 24'd420; head_id = 24'h51;
        pop_q.push_back(420);
        wait_time(422);
        check("emit_before_rst", 32'(evt_valid), 1);
        check("emit_id_before_rst", 32'(evt_id), 32'h51);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_evt_valid", 32'(evt_valid), 0);
        check("mid_rst_time", 32'(time_o), 0);
        check("mid_rst_pop", 32'(pop), 0);
        check("mid_rst_evt_id", 32'(evt_id), 0);
        rst_ni = 1'b1; evt_ready = 1'b1;
        head_data = 24'd5; head_id = 24'h52;
        pop_q.push_back(5); ev_q.push_back(mk(24'h52, 24'd5, 7));
        wait_time(6); head_valid = 1'b0;

        // Wrap on the 8-bit instance: 254 pops at 254 only, 5 not before 5, 254 expired at time 1.
        wait_time(240);
        w_head_valid = 1'b1; w_head_data = 8'd254; w_head_id = 24'd9;
        pop8_q.push_back(254); ev8_q.push_back(mk(24'd9, 24'd254, 0));
        wait_time(255); w_head_data = 8'd5; w_head_id = 24'd10;
        pop8_q.push_back(5); ev8_q.push_back(mk(24'd10, 24'd5, 7));
        wait_time(262); w_head_valid = 1'b0;
        wait_time(513);
        w_head_valid = 1'b1; w_head_data = 8'd254; w_head_id = 24'd11;
        pop8_q.push_back(1); ev8_q.push_back(mk(24'd11, 24'd254, 3));
        wait_time(514); w_head_valid = 1'b0;

        wait_time(520);
        check("pending_pops", 32'(pop_q.size()), 0);
        check("pending_evts", 32'(ev_q.size()), 0);
        check("w_pending_pops", 32'(pop8_q.size()), 0);
        check("w_pending_evts", 32'(ev8_q.size()), 0);
        check("w_late", 32'(w_late), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
